// File: rtl/sm_hex_scan.sv
// sm_hex_scan: multiplexed hex display scanner.
// Frame-synchronous display update, leading-zero blanking, registered outputs.
module sm_hex_scan #(
  parameter int DIGITS         = 8,
  parameter int PRESCALE       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dpMask,
  input  logic                  blankZeros,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig,
  output logic                  frameDone
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  localparam logic [6:0]        SEG_POL = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIG_POL = {DIGITS{DIG_ACTIVE_LOW}};

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic [4*DIGITS-1:0]   disp_val_q, disp_val_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     dig_q, dig_d;
  logic                  fd_q, fd_d;

  logic                  last_slot;
  logic                  frame_end;
  logic [DIGITS-1:0]     zero_up;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [DIGITS-1:0]     dig_hot;
  logic [6:0]            seg_hi;
  logic                  dp_hi;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  // Scan counters plus pending/display capture; display only changes at frame end.
  always_comb begin
    last_slot  = (cnt_q == CNT_LAST);
    frame_end  = last_slot && (idx_q == IDX_LAST);
    cnt_d      = last_slot ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    if (last_slot) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dpMask;
    end
    if (frame_end) begin
      disp_val_d = load ? value  : pend_val_q;
      disp_dp_d  = load ? dpMask : pend_dp_q;
    end
  end

  // zero_up[i] is set when nibbles i..DIGITS-1 of the display are all zero.
  always_comb begin
    logic run;
    zero_up = '0;
    run     = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run        = run & (disp_val_q[4*i +: 4] == 4'h0);
      zero_up[i] = run;
    end
  end

  // Output decode for the current slot, polarity applied before registering.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    dig_hot   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib    = disp_val_q[4*i +: 4];
        cur_dp     = disp_dp_q[i];
        cur_blank  = blankZeros && (i != 0) && zero_up[i];
        dig_hot[i] = 1'b1;
      end
    end
    if (cnt_q == '0) begin
      dig_hot = '0;
    end
    seg_hi = cur_blank ? 7'h00 : seg_decode(cur_nib);
    dp_hi  = cur_dp & ~cur_blank;
    seg_d  = seg_hi ^ SEG_POL;
    dp_d   = dp_hi ^ SEG_ACTIVE_LOW;
    dig_d  = dig_hot ^ DIG_POL;
    fd_d   = frame_end;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      seg_q      <= SEG_POL;
      dp_q       <= SEG_ACTIVE_LOW;
      dig_q      <= DIG_POL;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      dig_q      <= dig_d;
      fd_q       <= fd_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign dig       = dig_q;
  assign frameDone = fd_q;

endmodule

// File: tb/tb_sm_hex_scan.sv
// tb_sm_hex_scan: random stimulus against a frame-level reference model.
// DIGITS=4, PRESCALE=4, segments and digits active-low.
module tb_sm_hex_scan;

  localparam int D = 4;
  localparam int P = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   value;
  logic          load;
  logic [3:0]    dpMask;
  logic          blankZeros;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    dig;
  logic          frameDone;

  sm_hex_scan #(
    .DIGITS(D),
    .PRESCALE(P),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .load(load),
    .dpMask(dpMask),
    .blankZeros(blankZeros),
    .seg(seg),
    .dp(dp),
    .dig(dig),
    .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int n_vec = 0;
  int n_err = 0;

  // reference model state: cycles since reset, pending and shown values
  int          cyc;
  logic [15:0] m_pend, m_disp;
  logic [3:0]  m_pdp, m_ddp;

  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_dig;
  logic        e_fd;
  logic        e_rst;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // expected outputs for the coming edge, then advance the model
  task automatic model_step();
    int cnt, idx, nib;
    bit bnd, blank;
    logic [15:0] upper;
    e_rst = rst;
    if (rst) begin
      e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF; e_fd = 1'b0;
      cyc = 0; m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0;
      return;
    end
    cnt   = cyc % P;
    idx   = (cyc / P) % D;
    bnd   = (cyc % (P * D)) == (P * D - 1);
    upper = m_disp >> (4 * idx);
    nib   = int'(upper & 16'hF);
    blank = blankZeros && idx > 0 && upper == 16'h0;
    e_dig = (cnt == 0) ? 4'hF : ~(4'(1) << idx);
    e_seg = blank ? 7'h7F : ~tbl[nib];
    e_dp  = blank ? 1'b1 : ~m_ddp[idx];
    e_fd  = bnd;
    if (bnd) begin
      m_disp = load ? value  : m_pend;
      m_ddp  = load ? dpMask : m_pdp;
    end
    if (load) begin
      m_pend = value;
      m_pdp  = dpMask;
    end
    cyc++;
  endtask

  function automatic logic [15:0] rand_val();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 4);
    v = v & ((32'd1 << (4 * k)) - 32'd1);
    return v[15:0];
  endfunction

  initial begin
    rst = 1'b1; value = '0; load = 1'b0; dpMask = '0; blankZeros = 1'b0;
    cyc = 0; m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      rst  = (t < 2) || (t == 700) || ($urandom_range(0, 499) == 0);
      load = ($urandom_range(0, 7) == 0);
      if (t == 300) begin
        load = 1'b0;
      end
      value  = rand_val();
      dpMask = 4'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        blankZeros = ~blankZeros;
      end
      model_step();
      @(posedge clk);
      #1;
      chk("dig", 16'(dig), 16'(e_dig));
      chk("frameDone", 16'(frameDone), 16'(e_fd));
      if (e_rst || e_dig != 4'hF) begin
        chk("seg", 16'(seg), 16'(e_seg));
        chk("dp", 16'(dp), 16'(e_dp));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sm_hex_scan.md
SM_HEX_SCAN -- requirements
Module: sm_hex_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of multiplexed hex digits (legal 1..16).
REQ-002 SHALL have parameter PRESCALE, default 50000, clock cycles per digit slot (legal >= 2).
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1, inverts seg and dp when 1.
REQ-004 SHALL have parameter DIG_ACTIVE_LOW, default 1, inverts dig when 1.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  in  1  clock; all state on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 value  in  4*DIGITS  hex value; nibble i drives digit i, digit 0 least significant.
REQ-009 load  in  1  capture strobe for value and dpMask.
REQ-010 dpMask  in  DIGITS  decimal point per digit, captured with value.
REQ-011 blankZeros  in  1  leading-zero blanking enable, sampled live.
REQ-012 seg  out  7  segments {g,f,e,d,c,b,a}, seg[0]=a, registered.
REQ-013 dp  out  1  decimal point, registered.
REQ-014 dig  out  DIGITS  one-hot digit select, registered.
REQ-015 frameDone  out  1  one-cycle pulse per completed frame, registered.

Function
REQ-016 SHALL keep a prescaler cnt (0..PRESCALE-1) and a digit index idx (0..DIGITS-1); cnt increments every cycle.
REQ-017 When cnt==PRESCALE-1: cnt SHALL go to 0 and idx SHALL advance, wrapping DIGITS-1 -> 0; with DIGITS=1, idx stays 0.
REQ-018 load=1 SHALL capture value/dpMask into a pending register; a later load overwrites it.
REQ-019 The display register SHALL update from pending only when cnt==PRESCALE-1 and idx==DIGITS-1 (frame boundary); no tearing mid-frame.
REQ-020 If load=1 on a frame-boundary cycle, the display register SHALL take value/dpMask directly in that cycle.
REQ-021 frameDone SHALL be 1 on the cycle after each frame-boundary cycle, else 0.
REQ-022 Outputs SHALL be registered: on the cycle after state (cnt, idx), outputs reflect that state.
REQ-023 Dead time: when cnt==0, dig SHALL be all inactive; otherwise only bit idx active.
REQ-024 Digit decode (active-high before polarity): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-025 With blankZeros=1, digit i>0 SHALL be blanked (seg all off, dp off) when nibbles i..DIGITS-1 of the display register are all zero; digit 0 is never blanked.
REQ-026 dp SHALL equal displayed dpMask[idx] unless blanked.
REQ-027 Polarity: seg/dp inverted when SEG_ACTIVE_LOW=1; dig inverted when DIG_ACTIVE_LOW=1; "off/inactive" is after polarity.

Reset
REQ-028 rst=1 SHALL clear cnt, idx, pending and display registers to 0 on the next edge; rst has priority over load.
REQ-029 During and on the cycle after reset: seg all off, dp off, dig all inactive, frameDone 0 (polarity applied).
REQ-030 Reset asserted mid-frame SHALL abandon the frame without a frameDone pulse; scanning restarts at idx 0, cnt 0.

Verification (DIGITS=4, PRESCALE=4, both polarities active-low)
REQ-031 Reset release, value 0 -> first cycle dig=4'b1111; slots of 4 cycles; digit i active for 3 cycles after 1 dead cycle; order 0,1,2,3,0; seg=~7'h3F.
REQ-032 load 0x1234 at idx=1 -> digits still show 0 until frame end; frameDone pulses; next frame digit3 seg=~7'h06, digit0 seg=~7'h66.
REQ-033 blankZeros=1, value 0x0050 -> digits 3,2 seg=7'h7F; digit1 ~7'h6D; digit0 ~7'h3F; value 0x0000 -> only digit0 lit.
REQ-034 load 0xABCD with dpMask 4'b0101 on frame-boundary cycle -> very next frame shows A,b,C,d; dp active on digits 0 and 2 only.
REQ-035 rst pulse at idx=2, cnt=2 -> next cycle all outputs inactive, no frameDone; scan restarts from digit 0 with display 0.
